// File: rtl/sbuf_rd_seq.sv
// sbuf_rd_seq: read-side sequencer for the systolic buffer RAM.
// Reads len consecutive words from base_adr and presents them on a valid/ready
// stream. A 2-entry output queue hides the RAM's one-cycle read latency.
module sbuf_rd_seq #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_adr,
    input  logic [AW-1:0] len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [AW-1:0] adr;          // next address to issue
    logic [AW-1:0] last_adr;     // most recently issued address
    logic [AW:0]   remaining;    // reads still to issue; one extra bit for 2**AW
    logic          inflight;     // a read was issued last cycle
    logic [DW-1:0] q0, q1;       // q0 is the head
    logic [1:0]    occ;
    logic          deq, issue, accept, flush, done_next;
    logic [2:0]    fill;         // queue level projected after this cycle

    assign deq       = (occ != 2'd0) && out_ready;
    assign fill      = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    assign out_valid = (occ != 2'd0);
    assign out_data  = q0;
    assign busy      = (state != IDLE);
    // The RAM registers the address, so the issued address must be visible in the issue cycle.
    assign ram_radr  = issue ? adr : last_adr;

    // Next-state, read issue and completion decisions
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        flush      = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = IDLE;
                end else begin
                    if ((remaining != '0) && (fill < 3'd2)) begin
                        issue = 1'b1;
                    end
                    if (issue && (remaining == {{AW{1'b0}}, 1'b1})) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = IDLE;
                end else if (fill == 3'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, address/count bookkeeping and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            adr       <= '0;
            last_adr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= done_next;
            inflight <= issue;
            if (accept) begin
                adr       <= base_adr;
                remaining <= (len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, len};
            end else if (issue) begin
                adr       <= adr + 1'b1;
                last_adr  <= adr;
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Two-entry output queue: returning read data enqueues, handshake dequeues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0  <= '0;
            q1  <= '0;
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            unique case ({inflight, deq})
                2'b01: begin
                    q0  <= q1;
                    occ <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) q0 <= ram_rdata;
                    else             q1 <= ram_rdata;
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    // Level unchanged: new word goes behind whatever remains after the pop.
                    if (occ == 2'd1) begin
                        q0 <= ram_rdata;
                    end else begin
                        q0 <= q1;
                        q1 <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
